// File: rtl/video_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// video_pkg : shared video-path types and default frame geometry
// Rev 1.0
// ---------------------------------------------------------------------------
package video_pkg;

   localparam int HDISP_DEF = 800;
   localparam int VDISP_DEF = 480;

   // {8'h00, R, G, B}
   typedef logic [31:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/wshb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wshb_if : classic Wishbone bus bundle (single-read subset used by the fetcher)
// Rev 1.0
// ---------------------------------------------------------------------------
interface wshb_if;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] adr;
   logic        ack;
   logic [31:0] dat_sm;

   modport master (
      output cyc, stb, we, sel, cti, bte, adr,
      input  ack, dat_sm
   );

   modport slave (
      input  cyc, stb, we, sel, cti, bte, adr,
      output ack, dat_sm
   );

endinterface
`default_nettype wire

// File: rtl/wshb_frame_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wshb_frame_reader : raster-order framebuffer fetch over Wishbone into pixel FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module wshb_frame_reader
   import video_pkg::*;
#(
   parameter int          HDISP     = HDISP_DEF,
   parameter int          VDISP     = VDISP_DEF,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic   clk,
   input  logic   rst,
   wshb_if.master wshb_ifm,
   input  logic   frame_start,
   input  logic   fifo_walmost_full,
   output logic   fifo_write,
   output pixel_t fifo_wdata,
   output logic   resync_err
);

   localparam int NPIX  = HDISP * VDISP;
   localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

   fetch_state_t     state;
   logic [IDX_W-1:0] idx;
   logic             pending_resync;
   logic             req;
   logic [31:0]      adr;

   logic ack;
   logic last;

   // stb and cyc are one register: a single read is never split
   assign wshb_ifm.cyc = req;
   assign wshb_ifm.stb = req;
   assign wshb_ifm.we  = 1'b0;
   assign wshb_ifm.sel = 4'b1111;
   assign wshb_ifm.cti = 3'b000;
   assign wshb_ifm.bte = 2'b00;
   assign wshb_ifm.adr = adr;

   assign ack  = req & wshb_ifm.ack;
   assign last = (idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         pending_resync <= 1'b0;
         req            <= 1'b0;
         adr            <= BASE_ADDR;
         fifo_write     <= 1'b0;
         fifo_wdata     <= '0;
         resync_err     <= 1'b0;
      end else begin
         fifo_write <= 1'b0;
         resync_err <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (frame_start) begin
                  idx   <= '0;
                  adr   <= BASE_ADDR;
                  state <= FETCH;
                  req   <= 1'b1;
               end
            end
            FETCH: begin
               if (ack) begin
                  fifo_write     <= 1'b1;
                  fifo_wdata     <= wshb_ifm.dat_sm;
                  pending_resync <= 1'b0;
                  if (pending_resync || frame_start || last) begin
                     idx        <= '0;
                     adr        <= BASE_ADDR;
                     // a start landing on the final ack is a clean frame boundary
                     resync_err <= frame_start & ~last;
                     if (!pending_resync && !frame_start) begin
                        state <= DONE;
                        req   <= 1'b0;
                     end else if (fifo_walmost_full) begin
                        state <= WAIT;
                        req   <= 1'b0;
                     end
                  end else begin
                     idx <= idx + 1'b1;
                     adr <= adr + 32'd4;
                     if (fifo_walmost_full) begin
                        state <= WAIT;
                        req   <= 1'b0;
                     end
                  end
               end else if (frame_start) begin
                  pending_resync <= 1'b1;
                  resync_err     <= 1'b1;
               end
            end
            WAIT: begin
               if (frame_start) begin
                  idx        <= '0;
                  adr        <= BASE_ADDR;
                  resync_err <= 1'b1;
               end
               if (!fifo_walmost_full) begin
                  state <= FETCH;
                  req   <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               req   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/wshb_frame_reader.md
# wshb_frame_reader

Wishbone-master framebuffer fetch stage, directly upstream of the VGA output stage. Reads an HDISP×VDISP frame of 32-bit pixels from SDRAM in raster order using classic Wishbone single reads and pushes each returned word into the write port of the pixel FIFO. The VGA stage drains that FIFO. A frame-start pulse, already synchronised into this clock domain elsewhere, restarts the fetch at pixel 0 each frame.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- BASE_ADDR, 32'h0, byte address of pixel (0,0) in SDRAM
- clk  in  1  Wishbone clock; the single clock of the block
- rst  in  1  asynchronous, active-high reset
- wshb_ifm  wshb_if.master  —  Wishbone bus
  - drives cyc, stb, we, sel, cti, bte, adr
  - samples ack, dat_sm
- frame_start  in  1  one-cycle pulse: begin a new frame
- fifo_walmost_full  in  1  FIFO has ≤2 free words
- fifo_write  out  1  one-cycle write strobe into the FIFO
- fifo_wdata  out  32  pixel word, {8'h00, R, G, B}
- resync_err  out  1  one-cycle pulse: frame_start arrived before the frame was complete

## Operation
- Constants:
  - NPIX = HDISP*VDISP
  - index counter idx is $clog2(NPIX) bits
  - adr = BASE_ADDR + 4*idx, computed in 32 bits
- Fixed bus fields: we=0, sel=4'b1111, cti=3'b000, bte=2'b00.
- States:
  - IDLE
    - cyc=stb=0.
    - Entered from reset.
    - On frame_start: idx←0, go to FETCH.
  - FETCH
    - cyc=stb=1, adr from idx.
    - stb is never dropped before ack.
    - On ack:
      - fifo_wdata←dat_sm, fifo_write←1 on the next cycle, idx++.
      - If idx==NPIX-1: idx←0, go to DONE.
      - Else if fifo_walmost_full: go to WAIT.
      - Else stay in FETCH.
  - WAIT
    - cyc=stb=0.
    - When fifo_walmost_full==0: go to FETCH.
  - DONE
    - cyc=stb=0.
    - On frame_start: idx←0, go to FETCH.
- Resync, when frame_start arrives in FETCH or WAIT:
  - Set pending_resync.
  - In WAIT: idx←0 immediately, go to FETCH if not almost full.
  - In FETCH with no ack this cycle: hold stb until ack. Push that word, then idx←0 and continue FETCH from pixel 0.
  - In both cases resync_err pulses once.
- frame_start in the same cycle as the final ack (idx==NPIX-1):
  - Treated as a normal frame start, no resync_err.
  - The last word is pushed, then idx←0 and the state stays in FETCH.
- The module never writes when fifo_walmost_full has been high at an ack decision point. The two-word margin absorbs the registered push.

## Timing
- Reset values:
  - cyc=0, stb=0, adr=BASE_ADDR
  - fifo_write=0, fifo_wdata=0, resync_err=0
  - state=IDLE, idx=0, pending_resync=0
- frame_start at cycle t in IDLE/DONE → cyc=stb=1 with adr=BASE_ADDR at t+1.
- ack at cycle t → fifo_write=1 and fifo_wdata=dat_sm(t) at t+1. adr advances at t+1 if the state remains FETCH.
- Back-to-back acks with the FIFO not full give one pixel per clock.
- resync_err is registered and pulses at t+1 after the offending frame_start.
- rst mid-transfer aborts immediately: cyc/stb drop asynchronously and any in-flight data is discarded.

## Structure
- Shared package (video_pkg):
  - localparams HDISP_DEF=800, VDISP_DEF=480
  - pixel word typedef
  - fetch state enum {IDLE, FETCH, WAIT, DONE}
- No sub-module. The index counter with address generation is inline. The FIFO is instantiated by the parent, not here.

## Test plan
- Reset, no frame_start for 100 cycles → cyc=stb=0, fifo_write never asserted.
- HDISP=4, VDISP=2, slave acks every cycle, frame_start once:
  - exactly 8 fifo_write pulses
  - adr sequence 0,4,…,28
  - ends in DONE with cyc=0
- fifo_walmost_full asserted after 3rd ack for 10 cycles:
  - no stb during those cycles
  - fetch resumes at adr=12
  - total writes still 8
- frame_start after 5 acks, slave ack delayed 3 cycles:
  - in-flight word pushed
  - next adr=0
  - resync_err one pulse
- frame_start coincident with final ack → 8th word pushed, next adr=0, resync_err stays 0.
- rst asserted while stb=1 awaiting ack → cyc/stb=0 in the same cycle, no fifo_write; frame_start after release restarts at adr=BASE_ADDR.
